// File: rtl/soc_err_slave_pkg.sv
// SoC-level address map and shared types for the crossbar glue, including the
// state encodings and response code of the default error responder.
package ariane_soc;

  localparam int unsigned IdWidthSlave = 6;
  localparam int unsigned AddrWidth    = 64;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } err_wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } err_rd_state_e;

  // ErrSlave is the crossbar default port; it has no region of its own.
  typedef enum int unsigned {
    Debug    = 0,
    ROM      = 1,
    CLINT    = 2,
    PLIC     = 3,
    UART     = 4,
    DRAM     = 5,
    ErrSlave = 6
  } axi_slaves_e;

  localparam int unsigned NrRegions = 6;

  localparam logic [AddrWidth-1:0] DebugBase = 64'h0000_0000;
  localparam logic [AddrWidth-1:0] ROMBase   = 64'h0001_0000;
  localparam logic [AddrWidth-1:0] CLINTBase = 64'h0200_0000;
  localparam logic [AddrWidth-1:0] PLICBase  = 64'h0C00_0000;
  localparam logic [AddrWidth-1:0] UARTBase  = 64'h1000_0000;
  localparam logic [AddrWidth-1:0] DRAMBase  = 64'h8000_0000;

  localparam logic [AddrWidth-1:0] DebugLength = 64'h1000;
  localparam logic [AddrWidth-1:0] ROMLength   = 64'h1_0000;
  localparam logic [AddrWidth-1:0] CLINTLength = 64'hC_0000;
  localparam logic [AddrWidth-1:0] PLICLength  = 64'h3FF_FFFF;
  localparam logic [AddrWidth-1:0] UARTLength  = 64'h1000;
  localparam logic [AddrWidth-1:0] DRAMLength  = 64'h4000_0000;

  // Any address outside every region is routed to ErrSlave.
  function automatic logic valid_rule(input logic [AddrWidth-1:0] addr);
    logic hit;
    hit = 1'b0;
    if (addr >= DebugBase && addr < DebugBase + DebugLength) hit = 1'b1;
    if (addr >= ROMBase   && addr < ROMBase   + ROMLength)   hit = 1'b1;
    if (addr >= CLINTBase && addr < CLINTBase + CLINTLength) hit = 1'b1;
    if (addr >= PLICBase  && addr < PLICBase  + PLICLength)  hit = 1'b1;
    if (addr >= UARTBase  && addr < UARTBase  + UARTLength)  hit = 1'b1;
    if (addr >= DRAMBase  && addr < DRAMBase  + DRAMLength)  hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/soc_err_slave.sv
// Default AXI4 responder: drains unmapped writes and reads with DECERR and
// counts rejected transactions in a saturating counter.
module soc_err_slave
  import ariane_soc::*;
#(
  parameter int unsigned          IdWidth    = IdWidthSlave,
  parameter int unsigned          DataWidth  = 64,
  parameter logic [DataWidth-1:0] PoisonData = 64'hDEAD_BEEF_BADC_AB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [31:0]          err_cnt_o
);

  err_wr_state_e      wr_state;
  err_rd_state_e      rd_state;
  logic [IdWidth-1:0] b_id;
  logic [IdWidth-1:0] r_id;
  logic [7:0]         r_len;
  logic [7:0]         beat;
  logic [31:0]        err_cnt;
  logic               b_done;
  logic               r_done;
  logic [32:0]        cnt_sum;

  // Handshake outputs decode registered state only; no input-to-output path.
  assign aw_ready_o = (wr_state == W_IDLE);
  assign w_ready_o  = (wr_state == W_DATA);
  assign b_valid_o  = (wr_state == W_RESP);
  assign ar_ready_o = (rd_state == R_IDLE);
  assign r_valid_o  = (rd_state == R_DATA);
  assign r_last_o   = (rd_state == R_DATA) && (beat == r_len);

  assign b_id_o    = b_id;
  assign r_id_o    = r_id;
  assign b_resp_o  = RESP_DECERR;
  assign r_resp_o  = RESP_DECERR;
  assign r_data_o  = PoisonData;
  assign err_cnt_o = err_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_state <= W_IDLE;
      b_id     <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (aw_valid_i) begin
          b_id     <= aw_id_i;
          wr_state <= W_DATA;
        end
        W_DATA: if (w_valid_i && w_last_i) wr_state <= W_RESP;
        W_RESP: if (b_ready_i) wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_state <= R_IDLE;
      r_id     <= '0;
      r_len    <= '0;
      beat     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (ar_valid_i) begin
          r_id     <= ar_id_i;
          r_len    <= ar_len_i;
          beat     <= '0;
          rd_state <= R_DATA;
        end
        R_DATA: if (r_ready_i) begin
          if (beat == r_len) rd_state <= R_IDLE;
          else               beat     <= beat + 8'd1;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign b_done  = b_valid_o && b_ready_i;
  assign r_done  = r_valid_o && r_last_o && r_ready_i;
  assign cnt_sum = {1'b0, err_cnt} + {32'd0, b_done} + {32'd0, r_done};

  // A carry out of bit 31 means the true count passed the top; pin it there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_cnt <= '0;
    else         err_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end

endmodule

// File: tb/tb_soc_err_slave.sv
// Bench for soc_err_slave: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the responder.
module tb_soc_err_slave;

  localparam int unsigned   IW     = 6;
  localparam logic [63:0]   POISON = 64'hDEAD_BEEF_BADC_AB1E;
  localparam longint        SAT    = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic          b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [IW-1:0] aw_id, b_id, ar_id, r_id;
  logic [7:0]    ar_len;
  logic [1:0]    b_resp, r_resp;
  logic [63:0]   r_data;
  logic [31:0]   err_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model: a write is "open" from AW acceptance to B acceptance, with its
  // response owed once the last W beat arrives; a read owes rd_left beats.
  bit          wr_open, resp_owed;
  logic [IW-1:0] m_bid, m_rid;
  int          rd_left;
  longint      m_cnt;

  soc_err_slave #(.IdWidth(IW), .DataWidth(64), .PoisonData(POISON)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("aw_ready", 64'(aw_ready), 64'(!wr_open));
    chk("w_ready",  64'(w_ready),  64'(wr_open && !resp_owed));
    chk("b_valid",  64'(b_valid),  64'(resp_owed));
    chk("b_id",     64'(b_id),     64'(m_bid));
    chk("b_resp",   64'(b_resp),   64'd3);
    chk("ar_ready", 64'(ar_ready), 64'(rd_left == 0));
    chk("r_valid",  64'(r_valid),  64'(rd_left > 0));
    chk("r_last",   64'(r_last),   64'(rd_left == 1));
    chk("r_id",     64'(r_id),     64'(m_rid));
    chk("r_data",   r_data,        POISON);
    chk("r_resp",   64'(r_resp),   64'd3);
    chk("err_cnt",  64'(err_cnt),  64'(m_cnt));
  endtask

  task automatic model_reset();
    wr_open = 0; resp_owed = 0; rd_left = 0; m_bid = '0; m_rid = '0; m_cnt = 0;
  endtask

  // Apply the currently driven inputs for one clock, advance the model, check.
  task automatic step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, r_end;
    if (!rst_n) model_reset();
    else begin
      aw_hs = aw_valid && !wr_open;
      w_hs  = w_valid && wr_open && !resp_owed;
      b_hs  = b_ready && resp_owed;
      ar_hs = ar_valid && rd_left == 0;
      r_hs  = r_ready && rd_left > 0;
      r_end = r_hs && rd_left == 1;
      m_cnt = m_cnt + longint'(b_hs) + longint'(r_end);
      if (m_cnt > SAT) m_cnt = SAT;
      if (aw_hs) begin wr_open = 1; m_bid = aw_id; end
      if (w_hs && w_last) resp_owed = 1;
      if (b_hs) begin wr_open = 0; resp_owed = 0; end
      if (ar_hs) begin rd_left = int'(ar_len) + 1; m_rid = ar_id; end
      if (r_hs) rd_left--;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    aw_valid = 0; w_valid = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; r_ready = 0; aw_id = '0; ar_id = '0; ar_len = '0;
  endtask

  initial begin
    logic [3:0] lasts;
    int         hs;
    rst_n = 0;
    idle();
    model_reset();
    @(negedge clk);
    step(); step();
    rst_n = 1;
    step();
    chk("reset_aw_ready", 64'(aw_ready), 64'd1);
    chk("reset_err_cnt",  64'(err_cnt),  64'd0);

    // Single write, id 2A
    aw_valid = 1; aw_id = 6'h2A; step();
    idle(); w_valid = 1; w_last = 1; step();
    chk("wr_b_valid", 64'(b_valid), 64'd1);
    chk("wr_b_id",    64'(b_id),    64'h2A);
    idle(); b_ready = 1; step();
    chk("wr_cnt", 64'(err_cnt), 64'd1);

    // Read burst len 3, no backpressure
    idle(); ar_valid = 1; ar_id = 6'h05; ar_len = 8'd3; r_ready = 1; step();
    ar_valid = 0;
    lasts = '0;
    for (int i = 0; i < 4; i++) begin
      lasts[i] = r_last;
      chk("rd_ar_busy", 64'(ar_ready), 64'd0);
      step();
    end
    chk("rd_last_pattern", 64'(lasts), 64'h8);
    chk("rd_ar_back", 64'(ar_ready), 64'd1);
    chk("rd_cnt", 64'(err_cnt), 64'd2);

    // Read backpressure len 1, r_ready 0,1,0,1
    idle(); ar_valid = 1; ar_id = 6'h07; ar_len = 8'd1; step();
    ar_valid = 0; hs = 0;
    for (int i = 0; i < 4; i++) begin
      r_ready = (i % 2 == 1);
      if (r_valid && r_ready) hs++;
      step();
    end
    chk("bp_rd_handshakes", 64'(hs), 64'd2);
    chk("bp_rd_idle", 64'(ar_ready), 64'd1);
    chk("bp_rd_cnt", 64'(err_cnt), 64'd3);

    // Write backpressure: b_ready low 5 cycles
    idle(); aw_valid = 1; aw_id = 6'h13; step();
    idle(); w_valid = 1; step();
    w_last = 1; step();
    idle();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_wr_aw_ready", 64'(aw_ready), 64'd0);
      chk("bp_wr_b_valid",  64'(b_valid),  64'd1);
    end
    b_ready = 1; step();
    chk("bp_wr_cnt", 64'(err_cnt), 64'd4);

    // B handshake and last R handshake in the same cycle
    idle(); aw_valid = 1; aw_id = 6'h01; ar_valid = 1; ar_id = 6'h02; ar_len = 8'd0; step();
    idle(); w_valid = 1; w_last = 1; step();
    idle(); b_ready = 1; r_ready = 1; step();
    chk("both_cnt", 64'(err_cnt), 64'd6);

    // Saturation
    idle();
    force dut.err_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.err_cnt;
    m_cnt = 64'hFFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      ar_valid = 1; ar_len = 8'd0; r_ready = 1; step();
      ar_valid = 0; step();
    end
    chk("sat_cnt", 64'(err_cnt), 64'hFFFF_FFFF);
    aw_valid = 1; step(); idle(); w_valid = 1; w_last = 1; step();
    idle(); b_ready = 1; step();
    chk("sat_hold", 64'(err_cnt), 64'hFFFF_FFFF);

    // Reset in the middle of a 256-beat burst
    idle(); ar_valid = 1; ar_id = 6'h3C; ar_len = 8'd255; r_ready = 1; step();
    ar_valid = 0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 0; step();
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready), 64'd1);
    chk("rst_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1;
    ar_valid = 1; ar_id = 6'h11; ar_len = 8'd2; step();
    ar_valid = 0; lasts = '0;
    for (int i = 0; i < 3; i++) begin
      lasts[i] = r_last;
      step();
    end
    chk("rst_new_last", 64'(lasts), 64'h4);
    chk("rst_new_cnt", 64'(err_cnt), 64'd1);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      aw_valid = $urandom_range(0, 1);
      aw_id    = IW'($urandom);
      w_valid  = $urandom_range(0, 1);
      w_last   = ($urandom_range(0, 2) == 0);
      b_ready  = $urandom_range(0, 1);
      ar_valid = $urandom_range(0, 1);
      ar_id    = IW'($urandom);
      ar_len   = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      r_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
